// File: rtl/unified_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_ctrl_if
// Description : Request/response bus between the core memory port and the
//               unified instruction/data memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface unified_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  // Requester side (core datapath)
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Memory side (controller)
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/unified_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_ctrl
// Description : Unified instruction/data word memory with a single
//               valid/ready request port and a fixed response latency.
//               One request in flight; response is a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  unified_mem_ctrl_if.slave bus
);

  localparam int         IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] C_CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       off_q, off_d;
  logic             we_q, we_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;

  logic [31:0]      mem [DEPTH_WORDS];

  logic             w_accept;
  logic             w_enter_resp;
  logic             w_mem_wr;
  logic             w_unused_addr;

  // Address bits above the array index are deliberately ignored (silent wrap).
  assign w_unused_addr = ^bus.req_addr[ADDR_W-1:IDX_W+2];

  assign w_accept = bus.req_valid && ready_q;

  // Next-state, capture and response computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    off_d        = off_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    valid_d      = 1'b0;
    rdata_d      = '0;
    err_d        = 1'b0;
    w_enter_resp = 1'b0;

    if (w_accept) begin
      idx_d   = bus.req_addr[IDX_W+1:2];
      off_d   = bus.req_addr[1:0];
      we_d    = bus.req_we;
      wdata_d = bus.req_wdata;
      be_d    = bus.req_be;
      cnt_d   = C_CNT_LOAD;
      if (LATENCY == 1) state_d = RESP;
      else              state_d = WAIT;
    end else begin
      case (state_q)
        WAIT: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = RESP;
        end
        default: state_d = IDLE;
      endcase
    end

    // Ready is registered, so it is derived from where the FSM is going.
    ready_d = (state_d != WAIT);

    // The response is formed on the edge entering RESP; with single-cycle
    // latency that edge is the accept edge, hence the use of the *_d capture.
    if (state_d == RESP) begin
      w_enter_resp = 1'b1;
      valid_d      = 1'b1;
      if (off_d != 2'b00) err_d = 1'b1;
      else if (!we_d)     rdata_d = mem[idx_d];
    end
  end

  assign w_mem_wr = !reset && w_enter_resp && we_d && (off_d == 2'b00);

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  // Byte-lane store into the array on the RESP-entry edge; array is not reset.
  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be_d[i]) mem[idx_d][8*i +: 8] <= wdata_d[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule
`default_nettype wire
